// File: rtl/ureg_pkg.sv
// Shared definitions for the universal shift register: operation modes and legal widths.
package ureg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHL  = 3'b001,
    MODE_SHR  = 3'b010,
    MODE_ROL  = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_LOAD = 3'b101,
    MODE_CLR  = 3'b110,
    MODE_RSVD = 3'b111
  } ureg_mode_e;

  localparam int UREG_MIN_WIDTH = 2;
  localparam int UREG_MAX_WIDTH = 64;

endpackage

// File: rtl/ureg_cell.sv
// One-bit storage element with asynchronous active-low reset and a selectable active clock edge.
module ureg_cell #(
  parameter logic RST_VAL  = 1'b0,
  parameter bit   NEG_EDGE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic q_reg;

  generate
    if (NEG_EDGE) begin : g_neg
      always_ff @(negedge clk or negedge rst) begin
        if (!rst) q_reg <= RST_VAL;
        else      q_reg <= d;
      end
    end else begin : g_pos
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) q_reg <= RST_VAL;
        else      q_reg <= d;
      end
    end
  endgenerate

  assign q = q_reg;

endmodule

// File: rtl/ureg_shift.sv
// WIDTH-bit universal register (hold/shift/rotate/load/clear) with a word-serialisation counter.
// Define UREG_PARITY_EN to add a registered even-parity output par tracking ^q.
module ureg_shift
  import ureg_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter bit               NEG_EDGE = 1'b1,
  localparam int              CW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    cnt,
`ifdef UREG_PARITY_EN
  output logic             par,
`endif
  output logic             done
);

  generate
    if (WIDTH < UREG_MIN_WIDTH || WIDTH > UREG_MAX_WIDTH) begin : g_bad_width
      $error("ureg_shift: WIDTH out of range");
    end
  endgenerate

  ureg_mode_e       mode_e;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             done_reg, done_next;
  logic             shift_op;

  assign mode_e = ureg_mode_e'(mode);

  always_comb begin
    q_next    = q_reg;
    cnt_next  = cnt_reg;
    done_next = 1'b0;
    shift_op  = 1'b0;
    // With en low mode is never decoded, so an unknown mode cannot disturb state.
    if (en) begin
      case (mode_e)
        MODE_SHL: begin
          q_next   = {q_reg[WIDTH-2:0], sin_l};
          shift_op = 1'b1;
        end
        MODE_SHR: begin
          q_next   = {sin_r, q_reg[WIDTH-1:1]};
          shift_op = 1'b1;
        end
        MODE_ROL: begin
          q_next   = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
          shift_op = 1'b1;
        end
        MODE_ROR: begin
          q_next   = {q_reg[0], q_reg[WIDTH-1:1]};
          shift_op = 1'b1;
        end
        MODE_LOAD: begin
          q_next   = d;
          cnt_next = '0;
        end
        MODE_CLR: begin
          q_next   = '0;
          cnt_next = '0;
        end
        default: begin
          q_next = q_reg;
        end
      endcase
    end
    // Wrap at WIDTH-1 explicitly so non-power-of-two widths count whole words.
    if (shift_op) begin
      if (cnt_reg == CW'(WIDTH - 1)) begin
        cnt_next  = '0;
        done_next = 1'b1;
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_q
      ureg_cell #(.RST_VAL(RST_VAL[gi]), .NEG_EDGE(NEG_EDGE)) u_cell (
        .clk (clk),
        .rst (rst),
        .d   (q_next[gi]),
        .q   (q_reg[gi])
      );
    end
    for (gi = 0; gi < CW; gi++) begin : g_cnt
      ureg_cell #(.RST_VAL(1'b0), .NEG_EDGE(NEG_EDGE)) u_cell (
        .clk (clk),
        .rst (rst),
        .d   (cnt_next[gi]),
        .q   (cnt_reg[gi])
      );
    end
  endgenerate

  ureg_cell #(.RST_VAL(1'b0), .NEG_EDGE(NEG_EDGE)) u_done (
    .clk (clk),
    .rst (rst),
    .d   (done_next),
    .q   (done_reg)
  );

`ifdef UREG_PARITY_EN
  // Parity of the value being written, so it matches ^q after every edge and holds with q.
  ureg_cell #(.RST_VAL(^RST_VAL), .NEG_EDGE(NEG_EDGE)) u_par (
    .clk (clk),
    .rst (rst),
    .d   (^q_next),
    .q   (par)
  );
`endif

  assign q      = q_reg;
  assign nq     = ~q_reg;
  assign sout_l = q_reg[WIDTH-1];
  assign sout_r = q_reg[0];
  assign cnt    = cnt_reg;
  assign done   = done_reg;

endmodule
